// File: rtl/tone_sequencer.sv
// Programmable note sequencer feeding the sawtooth PWM tone generator.
// Define TONE_SEQ_LOOP_EN to wrap playback to entry 0 instead of finishing.
module tone_sequencer #(
  parameter int SEQ_LEN   = 16,
  parameter int TICK_DIV  = 256000,
  parameter int GAP_TICKS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(SEQ_LEN)-1:0] wr_addr,
  input  logic [23:0]                wr_data,
  input  logic                       start,
  input  logic                       stop,
  output logic [15:0]                note_freq,
  output logic                       gate,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(SEQ_LEN)-1:0] cur_idx
);

  localparam int AW = $clog2(SEQ_LEN);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int TW = ($clog2(GAP_TICKS + 1) > 8) ?
                      $clog2(GAP_TICKS + 1) : 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   idx, idx_n;
  logic [CW-1:0]   cyc;
  logic [TW-1:0]   tick;
  logic            cnt_clr;
  logic [23:0]     tbl [SEQ_LEN];

  logic [15:0]     note_n;
  logic            gate_n, busy_n, done_n;

  logic            active;
  logic            tick_end, play_end, gap_end;
  logic [AW-1:0]   nxt;
  logic            last;
  logic [7:0]      cur_dur;
  logic [7:0]      nxt_dur;
  logic [7:0]      first_dur;

  assign active    = (state == S_PLAY) || (state == S_GAP);
  assign cur_dur   = tbl[idx][7:0];
  assign nxt       = idx + AW'(1);
  assign nxt_dur   = tbl[nxt][7:0];
  assign first_dur = tbl[0][7:0];
  assign last      = (idx == AW'(SEQ_LEN - 1));
  assign tick_end  = (cyc == CW'(TICK_DIV - 1));
  assign play_end  = tick_end &&
                     (tick == TW'(cur_dur) - TW'(1));
  assign gap_end   = tick_end && (tick == TW'(GAP_TICKS - 1));

  // Table is frozen while playing, so entries are read in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SEQ_LEN; i++) tbl[i] <= '0;
    end else if (wr_en && !active) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      cyc   <= '0;
      tick  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (cnt_clr) begin
        cyc  <= '0;
        tick <= '0;
      end else if (active) begin
        if (tick_end) begin
          cyc  <= '0;
          tick <= tick + TW'(1);
        end else begin
          cyc <= cyc + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_clr = 1'b0;
    if (stop) begin
      state_n = S_IDLE;
      idx_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            idx_n   = '0;
            cnt_clr = 1'b1;
            state_n = (first_dur == 8'd0) ? S_DONE : S_PLAY;
          end
        end
        S_PLAY, S_GAP: begin
          if (state == S_PLAY && play_end && GAP_TICKS > 0) begin
            state_n = S_GAP;
            cnt_clr = 1'b1;
          end else if ((state == S_PLAY && play_end) ||
                       (state == S_GAP && gap_end)) begin
            cnt_clr = 1'b1;
            if (last || nxt_dur == 8'd0) begin
`ifdef TONE_SEQ_LOOP_EN
              idx_n   = '0;
              state_n = S_PLAY;
`else
              state_n = S_DONE;
`endif
            end else begin
              idx_n   = nxt;
              state_n = S_PLAY;
            end
          end
        end
        S_DONE: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they register in step.
  always_comb begin
    note_n = '0;
    gate_n = 1'b0;
    busy_n = (state_n == S_PLAY) || (state_n == S_GAP);
    done_n = (state_n == S_DONE);
    if (state_n == S_PLAY) begin
      note_n = tbl[idx_n][23:8];
      gate_n = (tbl[idx_n][23:8] != 16'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_freq <= '0;
      gate      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      note_freq <= note_n;
      gate      <= gate_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  assign cur_idx = idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer.
// Expected traces are built from the table by plain note arithmetic.
module tb_tone_sequencer;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int GT = 1;
`ifdef TONE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic        start;
  logic        stop;
  logic [15:0] note_freq;
  logic        gate;
  logic        busy;
  logic        done;
  logic [1:0]  cur_idx;

  int tests = 0;
  int fails = 0;

  logic [23:0] mt [N];
  logic [20:0] exp_q [$];

  tone_sequencer #(
    .SEQ_LEN  (N),
    .TICK_DIV (TD),
    .GAP_TICKS(GT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .stop     (stop),
    .note_freq(note_freq),
    .gate     (gate),
    .busy     (busy),
    .done     (done),
    .cur_idx  (cur_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] ev(int f, bit g, bit b,
                                     bit d, int i);
    return {16'(f), g, b, d, 2'(i)};
  endfunction

  // Returns 1 when the trace is two loop passes with no end.
  function automatic bit build();
    int i;
    int reps;
    int f;
    int d;
    exp_q.delete();
    if (mt[0][7:0] == 8'd0) begin
      exp_q.push_back(ev(0, 0, 0, 1, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 0));
      return 1'b0;
    end
    i = 0;
    reps = 0;
    for (int g = 0; g < 64; g++) begin
      f = int'(mt[i][23:8]);
      d = int'(mt[i][7:0]);
      repeat (d * TD) exp_q.push_back(ev(f, f != 0, 1, 0, i));
      repeat (GT * TD) exp_q.push_back(ev(0, 0, 1, 0, i));
      if (i == N - 1 || mt[(i + 1) % N][7:0] == 8'd0) begin
        if (LOOP) begin
          reps++;
          i = 0;
          if (reps == 2) return 1'b1;
        end else begin
          exp_q.push_back(ev(0, 0, 0, 1, i));
          exp_q.push_back(ev(0, 0, 0, 0, i));
          return 1'b0;
        end
      end else begin
        i++;
      end
    end
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [20:0] e);
    logic [20:0] o;
    o = {note_freq, gate, busy, done, cur_idx};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic load();
    for (int a = 0; a < N; a++) begin
      wr_en   = 1'b1;
      wr_addr = 2'(a);
      wr_data = mt[a];
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic play(string tag, int stop_at, bit poke);
    bit lp;
    int sa;
    lp = build();
    sa = stop_at;
    if (lp && sa < 0) sa = exp_q.size() - 1;
    start = 1'b1;
    foreach (exp_q[k]) begin
      step();
      start = 1'b0;
      wr_en = 1'b0;
      chk(tag, exp_q[k]);
      if (k == sa) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk({tag, "_stop"}, ev(0, 0, 0, 0, 0));
        step();
        chk({tag, "_stop_idle"}, ev(0, 0, 0, 0, 0));
        return;
      end
      if (poke && k == 3) begin
        wr_en   = 1'b1;
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = 24'($urandom);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    stop    = 1'b0;
    for (int a = 0; a < N; a++) mt[a] = '0;
    step();
    chk("reset", ev(0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_reset", ev(0, 0, 0, 0, 0));

    play("empty", -1, 1'b0);

    mt[0] = {16'd440, 8'd2};
    mt[1] = {16'd0,   8'd1};
    mt[2] = {16'd880, 8'd3};
    mt[3] = {16'd1234, 8'd0};
    load();
    play("directed", -1, 1'b0);
    play("poke", -1, 1'b1);
    play("replay", -1, 1'b0);

    for (int a = 0; a < N; a++) mt[a] = {16'(100 * (a + 1)), 8'd1};
    load();
    play("alldur1", -1, 1'b0);
    play("stop_e1", int'(mt[0][7:0]) * TD + GT * TD + 1, 1'b0);

    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop", ev(0, 0, 0, 0, 0));
    step();
    chk("start_stop_idle", ev(0, 0, 0, 0, 0));

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < N; a++) begin
        mt[a][23:8] = ($urandom_range(0, 3) == 0) ?
                      16'd0 : 16'($urandom_range(1, 20000));
        mt[a][7:0]  = 8'($urandom_range(a == 0 ? 1 : 0, 3));
      end
      load();
      play($sformatf("rand%0d", r),
           (r % 2 == 1) ? int'($urandom_range(0, 6)) : -1, 1'b0);
    end

    mt[0] = {16'd440, 8'd1};
    mt[1] = {16'd0,   8'd0};
    mt[2] = '0;
    mt[3] = '0;
    load();
    play("loop_tbl", -1, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_note", ev(440, 1, 1, 0, 0));
    #2 reset = 1'b1;
    #1;
    chk("async_reset", ev(0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < N; a++) mt[a] = '0;
    play("cleared", -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
